// File: rtl/game_state_ctrl_if.sv
// game_state_ctrl_if: game-logic status in, sequencer phase/score out.
interface game_state_ctrl_if #(parameter int OUT_WIDTH = 8) ();
  logic                 click;
  logic                 base1_nuked;
  logic                 base2_nuked;
  logic                 base3_nuked;
  logic [OUT_WIDTH-1:0] killcount;
  logic                 logic_rst;
  logic [1:0]           state;
  logic                 game_won;
  logic                 game_lost;
  logic [1:0]           bases_left;
  logic [OUT_WIDTH-1:0] final_score;
  logic [OUT_WIDTH-1:0] highscore;
  modport master (
    output click, base1_nuked, base2_nuked, base3_nuked, killcount,
    input  logic_rst, state, game_won, game_lost, bases_left, final_score, highscore
  );
  modport slave (
    input  click, base1_nuked, base2_nuked, base3_nuked, killcount,
    output logic_rst, state, game_won, game_lost, bases_left, final_score, highscore
  );
endinterface

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: title/restart/play/over sequencer with final and high score.
module game_state_ctrl #(
    parameter int OUT_WIDTH   = 8,
    parameter int WIN_KILLS   = 50,
    parameter int RST_CYCLES  = 4,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input logic clk,
    input logic rst,
    game_state_ctrl_if.slave bus
);
    localparam int MAXC = (RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    typedef enum logic [1:0] {IDLE, RESTART, PLAY, OVER} state_t;
    state_t               st;
    logic                 click_d, lrst, won, lost;
    logic [2:0]           nk, hit, nk_next;
    logic [1:0]           bl, bl_next;
    logic [CW-1:0]        cnt;
    logic [OUT_WIDTH-1:0] final_score, highscore;
    logic                 click_rise, all_nuked, win;
    assign click_rise = bus.click & ~click_d;
    assign hit        = {bus.base3_nuked, bus.base2_nuked, bus.base1_nuked};
    assign all_nuked  = &(nk | hit);
    assign win        = bus.killcount >= OUT_WIDTH'(WIN_KILLS);
    // latches only collect hits while playing and freeze for the final scene
    assign nk_next = (st == PLAY) ? (nk | hit) : (st == OVER) ? nk : 3'b000;
    assign bl_next = 2'd3 - ({1'b0, nk_next[0]} + {1'b0, nk_next[1]} + {1'b0, nk_next[2]});
    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= IDLE;
            lrst        <= 1'b1;
            won         <= 1'b0;
            lost        <= 1'b0;
            bl          <= 2'd3;
            final_score <= '0;
            highscore   <= '0;
            click_d     <= 1'b0;
            nk          <= 3'b000;
            cnt         <= '0;
        end else begin
            click_d <= bus.click;
            nk      <= nk_next;
            bl      <= bl_next;
            case (st)
                IDLE: if (click_rise) begin
                    st  <= RESTART;
                    cnt <= CW'(RST_CYCLES - 1);
                end
                RESTART: if (cnt == '0) begin
                    st   <= PLAY;
                    lrst <= 1'b0;
                end else cnt <= cnt - 1'b1;
                PLAY: if (all_nuked || win) begin
                    st          <= OVER;
                    cnt         <= CW'(HOLD_CYCLES - 1);
                    final_score <= bus.killcount;
                    highscore   <= (bus.killcount > highscore) ? bus.killcount : highscore;
                    lost        <= all_nuked;
                    won         <= ~all_nuked;
                end
                OVER: if (cnt != '0) cnt <= cnt - 1'b1;
                else if (click_rise) begin
                    st   <= RESTART;
                    cnt  <= CW'(RST_CYCLES - 1);
                    lrst <= 1'b1;
                    won  <= 1'b0;
                    lost <= 1'b0;
                end
            endcase
        end
    end
    assign bus.logic_rst   = lrst;
    assign bus.state       = st;
    assign bus.game_won    = won;
    assign bus.game_lost   = lost;
    assign bus.bases_left  = bl;
    assign bus.final_score = final_score;
    assign bus.highscore   = highscore;
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: vector table plus hand sequences, expectations queued per edge.
module tb_game_state_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    game_state_ctrl_if #(.OUT_WIDTH(8)) bus ();
    game_state_ctrl #(.OUT_WIDTH(8), .WIN_KILLS(50), .RST_CYCLES(4), .HOLD_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    typedef struct {
        logic       c;
        logic [2:0] b;
        logic [7:0] kc;
        logic [1:0] st;
        logic       won;
        logic       lost;
        int         bl;
        logic [7:0] fs;
        logic [7:0] hs;
    } vec_t;
    vec_t q[$];
    vec_t tbl[12];
    int errors = 0;
    int checks = 0;
    int stepno = 0;

    function automatic vec_t mk(logic c, logic [2:0] b, logic [7:0] kc, logic [1:0] st,
                                logic won, logic lost, int bl, logic [7:0] fs, logic [7:0] hs);
        vec_t v;
        v.c = c; v.b = b; v.kc = kc; v.st = st; v.won = won; v.lost = lost;
        v.bl = bl; v.fs = fs; v.hs = hs;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got %0h expected %0h", stepno, name, act, exp);
        end
    endtask

    task automatic compare();
        vec_t e;
        e = q.pop_front();
        chk("state", 32'(bus.state), 32'(e.st));
        chk("logic_rst", 32'(bus.logic_rst), 32'(e.st < 2'd2));
        chk("game_won", 32'(bus.game_won), 32'(e.won));
        chk("game_lost", 32'(bus.game_lost), 32'(e.lost));
        chk("final_score", 32'(bus.final_score), 32'(e.fs));
        chk("highscore", 32'(bus.highscore), 32'(e.hs));
        if (e.bl >= 0) chk("bases_left", 32'(bus.bases_left), 32'(e.bl));
    endtask

    task automatic step(input vec_t v);
        bus.click = v.c;
        {bus.base3_nuked, bus.base2_nuked, bus.base1_nuked} = v.b;
        bus.killcount = v.kc;
        q.push_back(v);
        @(posedge clk);
        #1;
        stepno++;
        compare();
    endtask

    task automatic go(logic c, logic [2:0] b, logic [7:0] kc, logic [1:0] st,
                      logic won, logic lost, int bl, logic [7:0] fs, logic [7:0] hs);
        step(mk(c, b, kc, st, won, lost, bl, fs, hs));
    endtask

    initial begin
        tbl[0]  = mk(0, 3'b000, 0,  0, 0, 0, 3,  0, 0);
        tbl[1]  = mk(1, 3'b000, 0,  1, 0, 0, 3,  0, 0);
        tbl[2]  = mk(1, 3'b000, 0,  1, 0, 0, -1, 0, 0);
        tbl[3]  = mk(1, 3'b111, 60, 1, 0, 0, -1, 0, 0);
        tbl[4]  = mk(0, 3'b000, 0,  1, 0, 0, 3,  0, 0);
        tbl[5]  = mk(0, 3'b000, 0,  2, 0, 0, 3,  0, 0);
        tbl[6]  = mk(0, 3'b001, 7,  2, 0, 0, -1, 0, 0);
        tbl[7]  = mk(0, 3'b000, 7,  2, 0, 0, 2,  0, 0);
        tbl[8]  = mk(0, 3'b100, 7,  2, 0, 0, -1, 0, 0);
        tbl[9]  = mk(0, 3'b000, 7,  2, 0, 0, 1,  0, 0);
        tbl[10] = mk(0, 3'b010, 7,  3, 0, 1, -1, 7, 7);
        tbl[11] = mk(0, 3'b000, 30, 3, 0, 1, 0,  7, 7);
        bus.click = 0; bus.base1_nuked = 0; bus.base2_nuked = 0; bus.base3_nuked = 0;
        bus.killcount = 0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) go(0, 3'b000, 0, 0, 0, 0, 3, 0, 0);
        rst = 1'b0;
        // first game: start, restart window, loss by three separate pulses
        for (int i = 0; i < 12; i++) step(tbl[i]);
        // hold after loss: rise at 5 held to 12 ignored, fresh rise at 14 restarts
        for (int k = 2; k <= 4; k++) go(0, 3'b000, 30, 3, 0, 1, 0, 7, 7);
        for (int k = 5; k <= 12; k++) go(1, (k == 6) ? 3'b111 : 3'b000, 99, 3, 0, 1, 0, 7, 7);
        go(0, 3'b000, 0, 3, 0, 1, 0, 7, 7);
        go(1, 3'b000, 0, 1, 0, 0, -1, 7, 7);
        for (int i = 0; i < 3; i++) go(0, 3'b000, 0, 1, 0, 0, -1, 7, 7);
        go(0, 3'b000, 0, 2, 0, 0, 3, 7, 7);
        // second game: win at exactly WIN_KILLS
        go(0, 3'b000, 10, 2, 0, 0, 3, 7, 7);
        go(0, 3'b000, 30, 2, 0, 0, 3, 7, 7);
        go(0, 3'b000, 49, 2, 0, 0, 3, 7, 7);
        go(0, 3'b000, 50, 3, 1, 0, 3, 50, 50);
        for (int k = 1; k <= 9; k++) go(0, 3'b000, 0, 3, 1, 0, 3, 50, 50);
        go(1, 3'b000, 0, 1, 0, 0, -1, 50, 50);
        for (int i = 0; i < 3; i++) go(0, 3'b000, 0, 1, 0, 0, -1, 50, 50);
        go(0, 3'b000, 0, 2, 0, 0, 3, 50, 50);
        // third game: last base and win in the same cycle, loss wins
        go(0, 3'b001, 0, 2, 0, 0, -1, 50, 50);
        go(0, 3'b000, 0, 2, 0, 0, 2, 50, 50);
        go(0, 3'b010, 0, 2, 0, 0, -1, 50, 50);
        go(0, 3'b000, 0, 2, 0, 0, 1, 50, 50);
        go(0, 3'b100, 50, 3, 0, 1, -1, 50, 50);
        for (int k = 1; k <= 8; k++) go(0, 3'b000, 0, 3, 0, 1, 0, 50, 50);
        go(1, 3'b000, 0, 3, 0, 1, 0, 50, 50);
        go(0, 3'b000, 0, 3, 0, 1, 0, 50, 50);
        go(1, 3'b000, 0, 1, 0, 0, -1, 50, 50);
        for (int i = 0; i < 3; i++) go(0, 3'b000, 0, 1, 0, 0, -1, 50, 50);
        go(0, 3'b000, 0, 2, 0, 0, 3, 50, 50);
        // fourth game: level inputs, score 20 keeps highscore
        go(0, 3'b011, 20, 2, 0, 0, -1, 50, 50);
        go(0, 3'b111, 20, 3, 0, 1, -1, 20, 50);
        go(0, 3'b000, 20, 3, 0, 1, 0, 20, 50);
        for (int k = 2; k <= 9; k++) go(0, 3'b000, 20, 3, 0, 1, 0, 20, 50);
        go(1, 3'b000, 0, 1, 0, 0, -1, 20, 50);
        for (int i = 0; i < 3; i++) go(0, 3'b000, 0, 1, 0, 0, -1, 20, 50);
        go(0, 3'b000, 0, 2, 0, 0, 3, 20, 50);
        // fifth game: reset while a base is latched
        go(0, 3'b001, 5, 2, 0, 0, -1, 20, 50);
        go(0, 3'b000, 5, 2, 0, 0, 2, 20, 50);
        rst = 1'b1;
        go(0, 3'b000, 5, 0, 0, 0, 3, 0, 0);
        rst = 1'b0;
        go(0, 3'b000, 0, 0, 0, 0, 3, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
